// File: rtl/snake_grid_renderer_if.sv
// snake_grid_renderer_if: pixel address, background image and colour bus between the VGA controller and the renderer
interface snake_grid_renderer_if;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_valid;
  logic [11:0] ext_rgb;
  logic [11:0] rgb_out;
  logic        rgb_valid;
  modport master (output pix_x, pix_y, pix_valid, ext_rgb, input rgb_out, rgb_valid);
  modport slave  (input pix_x, pix_y, pix_valid, ext_rgb, output rgb_out, rgb_valid);
endinterface

// File: rtl/snake_grid_renderer.sv
// snake_grid_renderer: vblank-built cell map of food and snakes with a 3-stage pixel colour pipeline; SNAKE_GRID_LINES_EN adds grid lines
module snake_grid_renderer #(
  parameter int CELL_SIZE  = 20,
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 24,
  parameter int COORD_W    = 5,
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 7,
  parameter int NUM_SNAKES = 2,
  parameter logic [11:0] FOOD_COLOR = 12'hfff,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] GRID_COLOR = 12'h333,
  parameter logic [12*NUM_SNAKES-1:0] SNAKE_COLOR = 24'h0f0ff0,
  parameter logic [12*NUM_SNAKES-1:0] HEAD_COLOR  = 24'h0a0f80
) (
  input  logic clk,
  input  logic rst,
  snake_grid_renderer_if.slave vga,
  input  logic vblank_start,
  input  logic [1:0] game_state,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic food_display,
  input  logic [NUM_SNAKES*MAX_LEN*COORD_W-1:0] snake_x_flat,
  input  logic [NUM_SNAKES*MAX_LEN*COORD_W-1:0] snake_y_flat,
  input  logic [NUM_SNAKES*LEN_W-1:0] snake_len_flat,
  output logic map_busy,
  output logic frame_drop
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW = $clog2(CELLS);
  localparam int SW = NUM_SNAKES > 1 ? $clog2(NUM_SNAKES) : 1;
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  typedef enum logic [2:0] {IDLE, SNAP, CLEAR, FOOD, DRAW} state_t;
  function automatic logic in_grid(input int x, input int y);
    return x < GRID_W && y < GRID_H;
  endfunction
  function automatic logic [AW-1:0] cell_addr(input int x, input int y);
    return AW'(y * GRID_W + x);
  endfunction
  state_t state;
  logic boot;
  logic [AW-1:0] clr_addr;
  logic [SW-1:0] sidx;
  logic [IW-1:0] seg;
  logic [COORD_W-1:0] fx, fy, seg_x, seg_y;
  logic fdisp;
  logic [NUM_SNAKES*MAX_LEN*COORD_W-1:0] sx, sy;
  logic [NUM_SNAKES*LEN_W-1:0] slen;
  logic [LEN_W-1:0] len_c [NUM_SNAKES];
  logic [2:0] map_mem [CELLS];
  logic we;
  logic [AW-1:0] waddr;
  logic [2:0] wdata;
  logic nxt_found;
  logic [SW-1:0] nxt_s;
  int nxt_start;
  // nxt_s is the highest snake at or below nxt_start with a nonzero length, so empty snakes cost no cycles
  always_comb begin
    for (int k = 0; k < NUM_SNAKES; k++)
      len_c[k] = slen[k*LEN_W +: LEN_W] > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : slen[k*LEN_W +: LEN_W];
    nxt_start = state == DRAW ? int'(sidx) - 1 : NUM_SNAKES - 1;
    nxt_found = 1'b0;
    nxt_s = '0;
    for (int k = 0; k < NUM_SNAKES; k++)
      if (k <= nxt_start && len_c[k] != '0) begin
        nxt_found = 1'b1;
        nxt_s = SW'(k);
      end
    seg_x = sx[(int'(sidx) * MAX_LEN + int'(seg)) * COORD_W +: COORD_W];
    seg_y = sy[(int'(sidx) * MAX_LEN + int'(seg)) * COORD_W +: COORD_W];
    we = 1'b0;
    waddr = clr_addr;
    wdata = '0;
    if (state == CLEAR) we = 1'b1;
    else if (state == FOOD) begin
      we = fdisp && in_grid(int'(fx), int'(fy));
      waddr = cell_addr(int'(fx), int'(fy));
      wdata = 3'd1;
    end else if (state == DRAW) begin
      we = in_grid(int'(seg_x), int'(seg_y));
      waddr = cell_addr(int'(seg_x), int'(seg_y));
      wdata = 3'(2 + 2 * int'(sidx) + (seg == '0 ? 1 : 0));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      boot <= 1'b1;
      map_busy <= 1'b1;
      frame_drop <= 1'b0;
      clr_addr <= '0;
      sidx <= '0;
      seg <= '0;
      fdisp <= 1'b0;
      slen <= '0;
    end else begin
      frame_drop <= vblank_start && map_busy;
      case (state)
        IDLE: if (vblank_start) begin
          state <= SNAP;
          map_busy <= 1'b1;
        end
        SNAP: begin
          fx <= food_x;
          fy <= food_y;
          fdisp <= food_display;
          sx <= snake_x_flat;
          sy <= snake_y_flat;
          slen <= snake_len_flat;
          clr_addr <= '0;
          state <= CLEAR;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == AW'(CELLS - 1)) begin
            boot <= 1'b0;
            state <= boot ? IDLE : FOOD;
            map_busy <= !boot;
          end
        end
        FOOD, DRAW: begin
          if (state == DRAW && seg != '0) seg <= seg - 1'b1;
          else if (nxt_found) begin
            state <= DRAW;
            sidx <= nxt_s;
            seg <= IW'(int'(len_c[nxt_s]) - 1);
          end else begin
            state <= IDLE;
            map_busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          map_busy <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk)
    if (we) map_mem[waddr] <= wdata;
  logic s1_v, s1_in, s1_line, s2_v, s2_in, s2_line;
  logic [AW-1:0] s1_addr;
  logic [2:0] s2_code;
  logic [11:0] s2_ext, code_rgb, pix_rgb;
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_v, s1_in, s1_line, s2_v, s2_in, s2_line} <= '0;
      s1_addr <= '0;
      s2_code <= '0;
      s2_ext <= '0;
      vga.rgb_out <= '0;
      vga.rgb_valid <= 1'b0;
    end else begin
      s1_v <= vga.pix_valid;
      s1_in <= in_grid(int'(vga.pix_x) / CELL_SIZE, int'(vga.pix_y) / CELL_SIZE);
      s1_addr <= cell_addr(int'(vga.pix_x) / CELL_SIZE, int'(vga.pix_y) / CELL_SIZE);
`ifdef SNAKE_GRID_LINES_EN
      s1_line <= int'(vga.pix_x) % CELL_SIZE == 0 || int'(vga.pix_y) % CELL_SIZE == 0;
`else
      s1_line <= 1'b0;
`endif
      s2_v <= s1_v;
      s2_in <= s1_in;
      s2_line <= s1_line;
      s2_code <= map_mem[s1_addr];
      s2_ext <= vga.ext_rgb;
      vga.rgb_valid <= s2_v;
      vga.rgb_out <= pix_rgb;
    end
  end
  // while the map is being rebuilt its contents are stale, so RUNNING shows plain background
  always_comb begin
    code_rgb = s2_code == 3'd1 ? FOOD_COLOR : s2_line ? GRID_COLOR : BG_COLOR;
    for (int s = 0; s < NUM_SNAKES; s++) begin
      if (s2_code == 3'(2 + 2 * s)) code_rgb = SNAKE_COLOR[12*s +: 12];
      if (s2_code == 3'(3 + 2 * s)) code_rgb = HEAD_COLOR[12*s +: 12];
    end
    pix_rgb = !s2_v ? 12'h000 :
              game_state == 2'b00 ? (map_busy || !s2_in ? BG_COLOR : code_rgb) :
              game_state == 2'b11 ? 12'h000 : s2_ext;
  end
endmodule
